// File: rtl/fm_sb_packer.sv
// Spy-buffer packer: queues wide ULT words in a small FIFO and serialises each
// into IN_W/SB_W beats (LSB chunk first) with start/end-of-frame markers.
module fm_sb_packer #(
  parameter int IN_W       = 256,
  parameter int SB_W       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_hs,
  input  logic                            rst_hs,
  input  logic                            in_valid,
  input  logic [IN_W-1:0]                 in_data,
  input  logic                            freeze,
  input  logic                            clr_cnt,
  output logic                            in_ready,
  output logic                            fm_valid,
  output logic [SB_W-1:0]                 fm_data,
  output logic                            fm_sof,
  output logic                            fm_eof,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     drop_cnt
);

  localparam int N      = IN_W / SB_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int CIDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N-1:0][SB_W-1:0]  hold_q, hold_d;

  logic [IN_W-1:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    full_q;
  logic [15:0]             drop_q, drop_d;

  logic                    valid_q, valid_d;
  logic [SB_W-1:0]         data_q, data_d;
  logic                    sof_q, sof_d;
  logic                    eof_q, eof_d;

  logic                    wr_en;
  logic                    drop;
  logic                    frame_done;
  logic                    pop;
  logic [IN_W-1:0]         head;

  // A word arriving while full is lost even if a pop happens on the same edge.
  assign wr_en      = in_valid && !full_q && !freeze;
  assign drop       = in_valid &&  full_q && !freeze;
  assign frame_done = (state_q == ST_IDLE) || (cnt_q == CNT_W'(N));
  assign pop        = frame_done && (level_q != '0) && !freeze;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    valid_d = 1'b0;
    data_d  = data_q;
    sof_d   = 1'b0;
    eof_d   = 1'b0;

    if (pop) begin
      hold_d  = head;
      data_d  = head[SB_W-1:0];
      valid_d = 1'b1;
      sof_d   = 1'b1;
      eof_d   = (N == 1);
      cnt_d   = CNT_W'(1);
      state_d = ST_SEND;
    end else if (state_q == ST_SEND && cnt_q != CNT_W'(N)) begin
      data_d  = hold_q[cnt_q[CIDX_W-1:0]];
      valid_d = 1'b1;
      eof_d   = (cnt_q == CNT_W'(N - 1));
      cnt_d   = cnt_q + CNT_W'(1);
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (clr_cnt) begin
      drop_d = '0;
    end else if (drop && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_hs or posedge rst_hs) begin
    if (rst_hs) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      drop_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      level_q  <= level_d;
      full_q   <= (level_d == LVL_W'(FIFO_DEPTH));
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: storage has no reset; the pointers and level alone decide what is valid.
  always_ff @(posedge clk_hs) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready   = !full_q;
  assign fm_valid   = valid_q;
  assign fm_data    = data_q;
  assign fm_sof     = sof_q;
  assign fm_eof     = eof_q;
  assign fifo_level = level_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_fm_sb_packer.sv
// Bench for fm_sb_packer: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, and a wide instance for drop saturation.
module tb_fm_sb_packer;

  localparam int IN_W  = 256;
  localparam int SB_W  = 32;
  localparam int DEPTH = 4;
  localparam int N     = IN_W / SB_W;
  localparam int WIDE  = 4096;

  logic              clk_hs = 1'b0;
  logic              rst_hs;
  logic              in_valid;
  logic [IN_W-1:0]   in_data;
  logic              freeze;
  logic              clr_cnt;
  logic              in_ready;
  logic              fm_valid;
  logic [SB_W-1:0]   fm_data;
  logic              fm_sof;
  logic              fm_eof;
  logic [2:0]        fifo_level;
  logic [15:0]       drop_cnt;

  logic              rst_w;
  logic              in_valid_w;
  logic [WIDE-1:0]   in_data_w;
  logic              clr_w;
  logic              in_ready_w;
  logic              fm_valid_w;
  logic [SB_W-1:0]   fm_data_w;
  logic              fm_sof_w;
  logic              fm_eof_w;
  logic [2:0]        fifo_level_w;
  logic [15:0]       drop_w;
  logic              wide_done = 1'b0;

  always #5 clk_hs = ~clk_hs;

  fm_sb_packer #(.IN_W(IN_W), .SB_W(SB_W), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk_hs(clk_hs), .rst_hs(rst_hs), .in_valid(in_valid), .in_data(in_data),
    .freeze(freeze), .clr_cnt(clr_cnt), .in_ready(in_ready), .fm_valid(fm_valid),
    .fm_data(fm_data), .fm_sof(fm_sof), .fm_eof(fm_eof), .fifo_level(fifo_level),
    .drop_cnt(drop_cnt)
  );

  fm_sb_packer #(.IN_W(WIDE), .SB_W(SB_W), .FIFO_DEPTH(DEPTH)) u_wide (
    .clk_hs(clk_hs), .rst_hs(rst_w), .in_valid(in_valid_w), .in_data(in_data_w),
    .freeze(1'b0), .clr_cnt(clr_w), .in_ready(in_ready_w), .fm_valid(fm_valid_w),
    .fm_data(fm_data_w), .fm_sof(fm_sof_w), .fm_eof(fm_eof_w), .fifo_level(fifo_level_w),
    .drop_cnt(drop_w)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus the frame being played out.
  logic [IN_W-1:0] m_q[$];
  logic [IN_W-1:0] m_cur;
  int              m_left = 0;
  int              m_idx;
  bit              m_full;
  logic            e_valid = 1'b0;
  logic [SB_W-1:0] e_data  = '0;
  logic            e_sof   = 1'b0;
  logic            e_eof   = 1'b0;
  logic [15:0]     e_drop  = '0;

  always @(posedge clk_hs or posedge rst_hs) begin
    if (rst_hs) begin
      m_q.delete();
      m_left  = 0;
      e_valid = 1'b0;
      e_sof   = 1'b0;
      e_eof   = 1'b0;
      e_drop  = '0;
    end else begin
      m_full = (m_q.size() == DEPTH);
      if (m_left > 0) begin
        m_idx   = N - m_left;
        e_valid = 1'b1;
        e_data  = m_cur[m_idx*SB_W +: SB_W];
        e_sof   = (m_idx == 0);
        e_eof   = (m_idx == N - 1);
        m_left--;
      end else if (m_q.size() > 0 && !freeze) begin
        m_cur   = m_q.pop_front();
        e_valid = 1'b1;
        e_data  = m_cur[SB_W-1:0];
        e_sof   = 1'b1;
        e_eof   = (N == 1);
        m_left  = N - 1;
      end else begin
        e_valid = 1'b0;
        e_sof   = 1'b0;
        e_eof   = 1'b0;
      end
      if (clr_cnt) e_drop = '0;
      if (in_valid && !freeze) begin
        if (m_full) begin
          if (!clr_cnt && e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
        end else begin
          m_q.push_back(in_data);
        end
      end
    end
  end

  always @(negedge clk_hs) begin
    check("fm_valid", fm_valid, e_valid);
    if (e_valid) begin
      check("fm_data", fm_data, e_data);
      check("fm_sof", fm_sof, e_sof);
      check("fm_eof", fm_eof, e_eof);
    end
    check("fifo_level", fifo_level, m_q.size());
    check("drop_cnt", drop_cnt, e_drop);
    check("in_ready", in_ready, m_q.size() != DEPTH);
  end

  typedef struct {
    int              cyc;
    logic [SB_W-1:0] d;
    logic            sof;
    logic            eof;
  } beat_t;

  beat_t cap[$];
  int    cyc  = 0;
  int    peak = 0;

  always @(posedge clk_hs) cyc <= cyc + 1;

  always @(negedge clk_hs) begin
    if (!rst_hs) begin
      if (fm_valid) cap.push_back('{cyc, fm_data, fm_sof, fm_eof});
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
  end

  function automatic logic [IN_W-1:0] make_word(input logic [23:0] tag);
    logic [IN_W-1:0] w;
    for (int j = 0; j < N; j++) w[j*SB_W +: SB_W] = {tag, 8'(j)};
    return w;
  endfunction

  task automatic push_word(input logic [IN_W-1:0] w, output int c);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk_hs);
    #1;
    c        = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_beats(input string name, input int n, input int budget);
    for (int i = 0; i < budget && cap.size() < n; i++) @(posedge clk_hs);
    #1;
    check(name, cap.size(), n);
  endtask

  initial begin
    logic [IN_W-1:0] w0;
    logic [IN_W-1:0] w1;
    int wr;
    int e;

    rst_hs = 1'b1; in_valid = 1'b0; in_data = '0; freeze = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(posedge clk_hs);
    #1;
    check("rst_fm_valid", fm_valid, 1'b0);
    check("rst_fm_data", fm_data, 32'h0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_drop", drop_cnt, 16'h0);
    #2 rst_hs = 1'b0;
    @(posedge clk_hs);
    #1;

    // Single word, bytes 0x00..0x1F ascending
    for (int b = 0; b < 32; b++) w0[b*8 +: 8] = 8'(b);
    cap.delete(); peak = 0;
    push_word(w0, wr);
    wait_beats("s1_beats", 8, 20);
    repeat (4) @(posedge clk_hs);
    #1;
    check("s1_total", cap.size(), 8);
    if (cap.size() == 8) begin
      check("s1_b0_cyc", cap[0].cyc, wr + 1);
      check("s1_b0_data", cap[0].d, 32'h03020100);
      check("s1_b0_sof", cap[0].sof, 1'b1);
      check("s1_b7_data", cap[7].d, 32'h1F1E1D1C);
      check("s1_b7_eof", cap[7].eof, 1'b1);
      check("s1_b7_cyc", cap[7].cyc, wr + 8);
    end
    check("s1_peak", peak, 1);
    check("s1_drop", drop_cnt, 16'h0);

    // Back-to-back three words
    cap.delete();
    for (int i = 0; i < 3; i++) push_word(make_word(24'hA00000 + 24'(i)), wr);
    wait_beats("s2_beats", 24, 40);
    if (cap.size() == 24) begin
      check("s2_contig", cap[23].cyc - cap[0].cyc, 23);
      check("s2_f0_b0", cap[0].d, 32'hA0000000);
      check("s2_f1_b0", cap[8].d, 32'hA0000100);
      check("s2_f1_sof", cap[8].sof, 1'b1);
      check("s2_f1_b7_eof", cap[15].eof, 1'b1);
      check("s2_f2_b7", cap[23].d, 32'hA0000207);
    end
    repeat (4) @(posedge clk_hs);

    // Overflow: six words in a row
    #1;
    cap.delete();
    for (int i = 0; i < 6; i++) begin
      push_word(make_word(24'hC00000 + 24'(i)), wr);
      if (i == 4) begin
        check("s3_level_full", fifo_level, 3'd4);
        check("s3_in_ready", in_ready, 1'b0);
      end
    end
    wait_beats("s3_beats", 40, 80);
    repeat (10) @(posedge clk_hs);
    #1;
    check("s3_total", cap.size(), 40);
    if (cap.size() == 40) begin
      check("s3_contig", cap[39].cyc - cap[0].cyc, 39);
      check("s3_last", cap[39].d, 32'hC0000407);
    end
    check("s3_drop", drop_cnt, 16'd1);

    // Freeze during beat 3 of word 0, word 1 queued, word 2 written while frozen
    cap.delete();
    w1 = make_word(24'hE00001);
    push_word(make_word(24'hE00000), wr);
    push_word(w1, wr);
    repeat (3) @(posedge clk_hs);
    #1;
    freeze = 1'b1;
    push_word(make_word(24'hE00002), wr);
    repeat (6) @(posedge clk_hs);
    #1;
    check("s4_idle", fm_valid, 1'b0);
    check("s4_w0_beats", cap.size(), 8);
    check("s4_level", fifo_level, 3'd1);
    freeze = 1'b0;
    e = cyc;
    wait_beats("s4_beats", 16, 30);
    if (cap.size() >= 16) begin
      check("s4_w1_cyc", cap[8].cyc, e + 1);
      check("s4_w1_b0", cap[8].d, w1[SB_W-1:0]);
      check("s4_w1_sof", cap[8].sof, 1'b1);
    end
    repeat (10) @(posedge clk_hs);
    #1;
    check("s4_total", cap.size(), 16);
    check("s4_drop", drop_cnt, 16'd1);

    // Reset during beat 4 with two words queued
    cap.delete();
    for (int i = 0; i < 3; i++) push_word(make_word(24'h500000 + 24'(i)), wr);
    repeat (3) @(posedge clk_hs);
    #2;
    check("s6_pre_level", fifo_level, 3'd2);
    rst_hs = 1'b1;
    #1;
    check("s6_valid", fm_valid, 1'b0);
    check("s6_data", fm_data, 32'h0);
    check("s6_sof", fm_sof, 1'b0);
    check("s6_eof", fm_eof, 1'b0);
    check("s6_level", fifo_level, 3'd0);
    check("s6_drop", drop_cnt, 16'h0);
    check("s6_in_ready", in_ready, 1'b1);
    @(posedge clk_hs);
    #3 rst_hs = 1'b0;
    cap.delete();
    repeat (12) @(posedge clk_hs);
    #1;
    check("s6_quiet", cap.size(), 0);
    push_word(make_word(24'h5F0000), wr);
    wait_beats("s6_beats", 8, 20);
    if (cap.size() >= 8) begin
      check("s6_new_sof", cap[0].sof, 1'b1);
      check("s6_new_cyc", cap[0].cyc, wr + 1);
      check("s6_new_b0", cap[0].d, 32'h5F000000);
    end

    for (int i = 0; i < 70000 && !wide_done; i++) @(posedge clk_hs);
    check("wide_done", wide_done, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Wide instance (128 beats per word): a continuous stream saturates drop_cnt.
  initial begin
    rst_w = 1'b1; in_valid_w = 1'b0; in_data_w = '1; clr_w = 1'b0;
    repeat (2) @(posedge clk_hs);
    #3 rst_w = 1'b0;
    @(posedge clk_hs);
    #1;
    in_valid_w = 1'b1;
    repeat (10) @(posedge clk_hs);
    #1;
    check("wide_drop_5", drop_w, 16'd5);
    repeat (66190) @(posedge clk_hs);
    #1;
    check("wide_sat", drop_w, 16'hFFFF);
    clr_w = 1'b1;
    @(posedge clk_hs);
    #1;
    check("wide_clr_wins", drop_w, 16'h0);
    clr_w = 1'b0;
    @(posedge clk_hs);
    #1;
    check("wide_after_clr", drop_w, 16'd1);
    in_valid_w = 1'b0;
    wide_done  = 1'b1;
  end

endmodule
